// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX operand stage: forwarding, load-use bubble, EX pipeline register
module id_ex_operand_stage #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    input  logic [AW-1:0]    wa_in,
    input  logic             regwrite_in,
    input  logic             memtoreg_in,
    input  logic [WIDTH-1:0] imm_in,
    input  logic             exmem_regwrite,
    input  logic [AW-1:0]    exmem_wa,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_regwrite,
    input  logic [AW-1:0]    memwb_wa,
    input  logic [WIDTH-1:0] memwb_result,
    input  logic             stall_in,
    input  logic             flush,
    output logic             stall_out,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_srca,
    output logic [WIDTH-1:0] ex_srcb,
    output logic [WIDTH-1:0] ex_imm,
    output logic [AW-1:0]    ex_wa,
    output logic             ex_regwrite,
    output logic             ex_memtoreg,
    output logic [1:0]       ex_fwda,
    output logic [1:0]       ex_fwdb
);

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    logic             ex_valid_q,    ex_valid_d;
    logic [WIDTH-1:0] ex_srca_q,     ex_srca_d;
    logic [WIDTH-1:0] ex_srcb_q,     ex_srcb_d;
    logic [WIDTH-1:0] ex_imm_q,      ex_imm_d;
    logic [AW-1:0]    ex_wa_q,       ex_wa_d;
    logic             ex_regwrite_q, ex_regwrite_d;
    logic             ex_memtoreg_q, ex_memtoreg_d;
    logic [1:0]       ex_fwda_q,     ex_fwda_d;
    logic [1:0]       ex_fwdb_q,     ex_fwdb_d;

    logic [1:0]       fwd_a, fwd_b;
    logic [WIDTH-1:0] opnd_a, opnd_b;
    logic             load_use;

    // Register 0 is hard-wired zero, so it must never pick up a forwarded value.
    function automatic logic [1:0] fwd_select(
        input logic [AW-1:0] addr,
        input logic          mem_we,
        input logic [AW-1:0] mem_wa,
        input logic          wb_we,
        input logic [AW-1:0] wb_wa
    );
        if (addr == '0)                   return FWD_RF;
        else if (mem_we && mem_wa == addr) return FWD_MEM;
        else if (wb_we && wb_wa == addr)   return FWD_WB;
        else                              return FWD_RF;
    endfunction

    always_comb begin
        fwd_a = fwd_select(ra1, exmem_regwrite, exmem_wa, memwb_regwrite, memwb_wa);
        fwd_b = fwd_select(ra2, exmem_regwrite, exmem_wa, memwb_regwrite, memwb_wa);

        case (fwd_a)
            FWD_MEM: opnd_a = exmem_result;
            FWD_WB:  opnd_a = memwb_result;
            default: opnd_a = (ra1 == '0) ? '0 : rd1;
        endcase

        case (fwd_b)
            FWD_MEM: opnd_b = exmem_result;
            FWD_WB:  opnd_b = memwb_result;
            default: opnd_b = (ra2 == '0) ? '0 : rd2;
        endcase
    end

    assign load_use = ex_valid_q && ex_memtoreg_q && (ex_wa_q != '0) && in_valid &&
                      ((ex_wa_q == ra1) || (ex_wa_q == ra2));

    assign stall_out = stall_in || load_use;

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_srca_d     = ex_srca_q;
        ex_srcb_d     = ex_srcb_q;
        ex_imm_d      = ex_imm_q;
        ex_wa_d       = ex_wa_q;
        ex_regwrite_d = ex_regwrite_q;
        ex_memtoreg_d = ex_memtoreg_q;
        ex_fwda_d     = ex_fwda_q;
        ex_fwdb_d     = ex_fwdb_q;

        if (stall_in) begin
            // hold: defaults above keep every field
        end else if (flush || load_use) begin
            ex_valid_d    = 1'b0;
            ex_srca_d     = '0;
            ex_srcb_d     = '0;
            ex_imm_d      = '0;
            ex_wa_d       = '0;
            ex_regwrite_d = 1'b0;
            ex_memtoreg_d = 1'b0;
            ex_fwda_d     = FWD_RF;
            ex_fwdb_d     = FWD_RF;
        end else begin
            ex_valid_d    = in_valid;
            ex_srca_d     = opnd_a;
            ex_srcb_d     = opnd_b;
            ex_imm_d      = imm_in;
            ex_wa_d       = wa_in;
            ex_regwrite_d = in_valid && regwrite_in;
            ex_memtoreg_d = in_valid && memtoreg_in;
            ex_fwda_d     = fwd_a;
            ex_fwdb_d     = fwd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            ex_srca_q     <= '0;
            ex_srcb_q     <= '0;
            ex_imm_q      <= '0;
            ex_wa_q       <= '0;
            ex_regwrite_q <= 1'b0;
            ex_memtoreg_q <= 1'b0;
            ex_fwda_q     <= FWD_RF;
            ex_fwdb_q     <= FWD_RF;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_srca_q     <= ex_srca_d;
            ex_srcb_q     <= ex_srcb_d;
            ex_imm_q      <= ex_imm_d;
            ex_wa_q       <= ex_wa_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memtoreg_q <= ex_memtoreg_d;
            ex_fwda_q     <= ex_fwda_d;
            ex_fwdb_q     <= ex_fwdb_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_srca     = ex_srca_q;
    assign ex_srcb     = ex_srcb_q;
    assign ex_imm      = ex_imm_q;
    assign ex_wa       = ex_wa_q;
    assign ex_regwrite = ex_regwrite_q;
    assign ex_memtoreg = ex_memtoreg_q;
    assign ex_fwda     = ex_fwda_q;
    assign ex_fwdb     = ex_fwdb_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

    typedef struct packed {
        logic        valid;
        logic [15:0] srca;
        logic [15:0] srcb;
        logic [15:0] imm;
        logic [2:0]  wa;
        logic        rw;
        logic        mtr;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } ex_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, regwrite_in, memtoreg_in;
    logic [2:0]  ra1, ra2, wa_in, exmem_wa, memwb_wa;
    logic [15:0] rd1, rd2, imm_in, exmem_result, memwb_result;
    logic        exmem_regwrite, memwb_regwrite, stall_in, flush;
    logic        stall_out, ex_valid, ex_regwrite, ex_memtoreg;
    logic [15:0] ex_srca, ex_srcb, ex_imm;
    logic [2:0]  ex_wa;
    logic [1:0]  ex_fwda, ex_fwdb;

    ex_t dut_s;
    ex_t m;
    int  n_checks = 0;
    int  n_fails  = 0;

    always #5 clk = ~clk;

    assign dut_s = {ex_valid, ex_srca, ex_srcb, ex_imm, ex_wa, ex_regwrite, ex_memtoreg, ex_fwda, ex_fwdb};

    id_ex_operand_stage #(.WIDTH(16), .AW(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2), .wa_in(wa_in), .regwrite_in(regwrite_in),
        .memtoreg_in(memtoreg_in), .imm_in(imm_in),
        .exmem_regwrite(exmem_regwrite), .exmem_wa(exmem_wa), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_wa(memwb_wa), .memwb_result(memwb_result),
        .stall_in(stall_in), .flush(flush), .stall_out(stall_out),
        .ex_valid(ex_valid), .ex_srca(ex_srca), .ex_srcb(ex_srcb), .ex_imm(ex_imm),
        .ex_wa(ex_wa), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
        .ex_fwda(ex_fwda), .ex_fwdb(ex_fwdb)
    );

    // Reference model: writers listed youngest first; the first matching writer supplies the value.
    function automatic logic [17:0] model_operand(input logic [2:0] a, input logic [15:0] rd);
        logic        w_en  [2];
        logic [2:0]  w_a   [2];
        logic [15:0] w_d   [2];
        logic [1:0]  w_sel [2];
        w_en[0] = exmem_regwrite; w_a[0] = exmem_wa; w_d[0] = exmem_result; w_sel[0] = 2'd2;
        w_en[1] = memwb_regwrite; w_a[1] = memwb_wa; w_d[1] = memwb_result; w_sel[1] = 2'd1;
        if (a == 3'd0) return 18'd0;
        for (int k = 0; k < 2; k++)
            if (w_en[k] && w_a[k] == a) return {w_sel[k], w_d[k]};
        return {2'd0, rd};
    endfunction

    function automatic logic model_stall();
        logic hazard;
        hazard = m.valid && m.mtr && (m.wa != 3'd0) && in_valid && (m.wa == ra1 || m.wa == ra2);
        return stall_in || hazard;
    endfunction

    function automatic ex_t model_next();
        ex_t n;
        n = m;
        if (reset) n = '0;
        else if (stall_in) n = m;
        else if (flush || (model_stall() && !stall_in)) n = '0;
        else begin
            {n.fa, n.srca} = model_operand(ra1, rd1);
            {n.fb, n.srcb} = model_operand(ra2, rd2);
            n.valid = in_valid;
            n.imm   = imm_in;
            n.wa    = wa_in;
            n.rw    = in_valid && regwrite_in;
            n.mtr   = in_valid && memtoreg_in;
        end
        return n;
    endfunction

    task automatic tick();
        ex_t nxt;
        nxt = model_next();
        @(posedge clk); #1;
        m = nxt;
    endtask

    task automatic set_idle();
        reset = 0; in_valid = 0; regwrite_in = 0; memtoreg_in = 0;
        ra1 = 0; ra2 = 0; rd1 = 0; rd2 = 0; wa_in = 0; imm_in = 0;
        exmem_regwrite = 0; exmem_wa = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_wa = 0; memwb_result = 0;
        stall_in = 0; flush = 0;
    endtask

    task automatic rand_decode();
        in_valid = 1'($urandom); regwrite_in = 1'($urandom); memtoreg_in = 1'($urandom);
        ra1 = 3'($urandom); ra2 = 3'($urandom); wa_in = 3'($urandom);
        rd1 = (ra1 == 0) ? 16'h0 : 16'($urandom);
        rd2 = (ra2 == 0) ? 16'h0 : 16'($urandom);
        imm_in = 16'($urandom);
        exmem_regwrite = 1'($urandom); exmem_wa = 3'($urandom); exmem_result = 16'($urandom);
        memwb_regwrite = 1'($urandom); memwb_wa = 3'($urandom); memwb_result = 16'($urandom);
    endtask

    task automatic test_reset();
        rand_decode(); reset = 1; stall_in = 1'($urandom); flush = 1'($urandom);
        tick(); tick();
        n_checks++;
        if (dut_s !== ex_t'(0)) begin
            n_fails++; $display("FAIL reset_regs: got %h exp %h", dut_s, ex_t'(0));
        end
        set_idle(); #1;
        n_checks++;
        if (stall_out !== 1'b0) begin
            n_fails++; $display("FAIL reset_stall_out: got %b exp 0", stall_out);
        end
    endtask

    task automatic test_plain_issue();
        set_idle(); in_valid = 1; ra1 = 2; ra2 = 3; rd1 = 16'h1111; rd2 = 16'h2222;
        wa_in = 1; regwrite_in = 1; imm_in = 16'h00F0;
        tick();
        n_checks++;
        if (ex_srca !== 16'h1111 || ex_srcb !== 16'h2222 || ex_fwda !== 2'd0 || ex_fwdb !== 2'd0 ||
            ex_valid !== 1'b1 || ex_regwrite !== 1'b1) begin
            n_fails++; $display("FAIL plain_issue: got %h exp srca=1111 srcb=2222 fwd=0", dut_s);
        end
    endtask

    task automatic test_double_forward();
        set_idle(); in_valid = 1; ra1 = 4; ra2 = 4; rd1 = 16'h0404; rd2 = 16'h0404;
        exmem_regwrite = 1; exmem_wa = 4; exmem_result = 16'hAAAA;
        memwb_regwrite = 1; memwb_wa = 4; memwb_result = 16'hBBBB;
        tick();
        n_checks++;
        if (ex_srca !== 16'hAAAA || ex_srcb !== 16'hAAAA || ex_fwda !== 2'd2 || ex_fwdb !== 2'd2) begin
            n_fails++; $display("FAIL fwd_exmem_priority: got %h exp srca=srcb=aaaa fwd=2", dut_s);
        end
        exmem_regwrite = 0;
        tick();
        n_checks++;
        if (ex_srca !== 16'hBBBB || ex_srcb !== 16'hBBBB || ex_fwda !== 2'd1 || ex_fwdb !== 2'd1) begin
            n_fails++; $display("FAIL fwd_memwb: got %h exp srca=srcb=bbbb fwd=1", dut_s);
        end
    endtask

    task automatic test_reg0_guard();
        set_idle(); in_valid = 1; ra1 = 0; rd1 = 0; ra2 = 0; rd2 = 0;
        exmem_regwrite = 1; exmem_wa = 0; exmem_result = 16'h5555;
        memwb_regwrite = 1; memwb_wa = 0; memwb_result = 16'h6666;
        tick();
        n_checks++;
        if (ex_srca !== 16'h0 || ex_fwda !== 2'd0 || ex_srcb !== 16'h0 || ex_fwdb !== 2'd0) begin
            n_fails++; $display("FAIL reg0_guard: got %h exp srca=srcb=0 fwd=0", dut_s);
        end
    endtask

    task automatic test_load_use();
        set_idle(); in_valid = 1; regwrite_in = 1; memtoreg_in = 1; wa_in = 5; imm_in = 16'h0010;
        tick();
        set_idle(); in_valid = 1; ra1 = 1; rd1 = 16'h0101; ra2 = 5; rd2 = 16'h0505; wa_in = 6; regwrite_in = 1;
        #1;
        n_checks++;
        if (stall_out !== 1'b1) begin
            n_fails++; $display("FAIL load_use_stall: got %b exp 1", stall_out);
        end
        tick();
        n_checks++;
        if (dut_s !== ex_t'(0)) begin
            n_fails++; $display("FAIL load_use_bubble: got %h exp %h", dut_s, ex_t'(0));
        end
        exmem_regwrite = 1; exmem_wa = 5; exmem_result = 16'hCAFE;
        #1;
        n_checks++;
        if (stall_out !== 1'b0) begin
            n_fails++; $display("FAIL load_use_one_cycle: got %b exp 0", stall_out);
        end
        tick();
        n_checks++;
        if (ex_srcb !== 16'hCAFE || ex_fwdb !== 2'd2 || ex_srca !== 16'h0101 || ex_valid !== 1'b1) begin
            n_fails++; $display("FAIL load_use_replay: got %h exp srcb=cafe fwdb=2", dut_s);
        end
    endtask

    task automatic test_stall_hold();
        ex_t snap;
        set_idle(); rand_decode(); in_valid = 1;
        tick();
        snap = dut_s;
        for (int c = 0; c < 3; c++) begin
            rand_decode(); stall_in = 1;
            #1;
            n_checks++;
            if (stall_out !== 1'b1) begin
                n_fails++; $display("FAIL stall_hold_out cyc%0d: got %b exp 1", c, stall_out);
            end
            tick();
            n_checks++;
            if (dut_s !== m) begin
                n_fails++; $display("FAIL stall_hold cyc%0d: got %h exp %h", c, dut_s, m);
            end
        end
        n_checks++;
        if (dut_s !== snap) begin
            n_fails++; $display("FAIL stall_frozen: got %h exp %h", dut_s, snap);
        end
    endtask

    task automatic test_flush();
        set_idle(); rand_decode(); in_valid = 1; regwrite_in = 1; flush = 1;
        tick();
        n_checks++;
        if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || dut_s !== ex_t'(0)) begin
            n_fails++; $display("FAIL flush_bubble: got %h exp %h", dut_s, ex_t'(0));
        end
    endtask

    task automatic test_stall_flush();
        ex_t snap;
        set_idle(); rand_decode(); in_valid = 1;
        tick();
        snap = dut_s;
        rand_decode(); stall_in = 1; flush = 1;
        tick();
        n_checks++;
        if (dut_s !== snap) begin
            n_fails++; $display("FAIL stall_beats_flush: got %h exp %h", dut_s, snap);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_idle(); in_valid = 1; regwrite_in = 1; memtoreg_in = 1; wa_in = 3;
        tick();
        set_idle(); in_valid = 1; ra1 = 3; rd1 = 16'h3333; reset = 1;
        tick();
        reset = 0; #1;
        n_checks++;
        if (dut_s !== ex_t'(0) || stall_out !== 1'b0) begin
            n_fails++; $display("FAIL reset_mid_stall: got %h stall %b exp 0 stall 0", dut_s, stall_out);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rand_decode();
            reset    = ($urandom_range(0, 99) < 3);
            stall_in = ($urandom_range(0, 99) < 15);
            flush    = ($urandom_range(0, 99) < 10);
            #1;
            n_checks++;
            if (stall_out !== model_stall()) begin
                n_fails++; $display("FAIL rand_stall_out cyc%0d: got %b exp %b", c, stall_out, model_stall());
            end
            tick();
            n_checks++;
            if (dut_s !== m) begin
                n_fails++; $display("FAIL rand_regs cyc%0d: got %h exp %h", c, dut_s, m);
            end
        end
    endtask

    initial begin
        m = '0;
        set_idle();
        @(negedge clk);
        test_reset();
        test_plain_issue();
        test_double_forward();
        test_reg0_guard();
        test_load_use();
        test_stall_hold();
        test_flush();
        test_stall_flush();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
